// File: rtl/spi_master_ctrl.sv
// SPI master for the converter configuration port: one frame of 1..32 bits per request,
// with selectable launch/sample edge and read-back capture into spi_rdata.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [4:0]  spi_rw_len,
  input  logic        spi_d_rise_align,
  input  logic [31:0] spi_wdata,
  input  logic        spi_wr_en,
  input  logic        spi_rd_en,
  output logic [31:0] spi_rdata,
  output logic        spi_busy,
  output logic        spi_done,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   div_cnt_reg;
  logic [5:0]      bit_cnt_reg;
  logic [4:0]      len_reg;
  logic            align_reg;
  logic            rd_reg;
  logic [31:0]     wdata_reg;
  logic [31:0]     cap_reg;

  logic            half_end;
  logic [4:0]      bit_idx;
  logic [4:0]      next_idx;
  logic [31:0]     cap_shift;
  logic [31:0]     len_mask;

  assign half_end  = (div_cnt_reg == DIV_LAST);
  assign bit_idx   = bit_cnt_reg[4:0];
  assign next_idx  = bit_idx - 5'd1;
  assign cap_shift = {cap_reg[30:0], spi_miso};
  assign len_mask  = 32'hFFFF_FFFF >> (5'd31 - len_reg);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg   <= S_IDLE;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      len_reg     <= '0;
      align_reg   <= 1'b0;
      rd_reg      <= 1'b0;
      wdata_reg   <= '0;
      cap_reg     <= '0;
      spi_rdata   <= '0;
      spi_busy    <= 1'b0;
      spi_done    <= 1'b0;
      spi_csb     <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      spi_done    <= 1'b0;
      div_cnt_reg <= half_end ? '0 : div_cnt_reg + CW'(1);
      case (state_reg)
        S_IDLE: begin
          div_cnt_reg <= '0;
          if (spi_wr_en || spi_rd_en) begin
            state_reg   <= S_SETUP;
            len_reg     <= spi_rw_len;
            align_reg   <= spi_d_rise_align;
            rd_reg      <= spi_rd_en;
            wdata_reg   <= spi_wdata;
            bit_cnt_reg <= {1'b0, spi_rw_len};
            cap_reg     <= '0;
            spi_csb     <= 1'b0;
            spi_busy    <= 1'b1;
            spi_mosi    <= spi_d_rise_align ? 1'b0 : spi_wdata[spi_rw_len];
          end
        end
        S_SETUP: begin
          // First SCLK rise happens on leaving SETUP
          if (half_end) begin
            state_reg <= S_SHIFT;
            spi_sclk  <= 1'b1;
            if (align_reg) spi_mosi <= wdata_reg[bit_idx];
            else           cap_reg  <= cap_shift;
          end
        end
        S_SHIFT: begin
          if (half_end) begin
            if (spi_sclk) begin
              spi_sclk <= 1'b0;
              if (align_reg)                spi_mosi <= spi_mosi;
              else if (bit_cnt_reg != 6'd0) spi_mosi <= wdata_reg[next_idx];
              if (align_reg) cap_reg <= cap_shift;
            end else if (bit_cnt_reg == 6'd0) begin
              state_reg <= S_HOLD;
            end else begin
              spi_sclk    <= 1'b1;
              bit_cnt_reg <= bit_cnt_reg - 6'd1;
              if (align_reg) spi_mosi <= wdata_reg[next_idx];
              else           cap_reg  <= cap_shift;
            end
          end
        end
        S_HOLD: begin
          if (half_end) begin
            state_reg <= S_GAP;
            spi_csb   <= 1'b1;
            spi_done  <= 1'b1;
            spi_mosi  <= 1'b0;
            if (rd_reg) spi_rdata <= cap_reg & len_mask;
          end
        end
        S_GAP: begin
          if (half_end) begin
            state_reg <= S_IDLE;
            spi_busy  <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl at CLK_DIV = 1, 2 and 4, with a bit-level slave model
// and frame-level expectations derived from the frame timing rules.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  bit blk_done [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_div
    localparam int D = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;

    logic        rstb;
    logic [4:0]  len;
    logic        align;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic        miso;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        csb;
    logic        sclk;
    logic        mosi;
    logic [31:0] exp_rdata;

    spi_master_ctrl #(.CLK_DIV(D)) u_dut (
      .clk              (clk),
      .rstb             (rstb),
      .spi_rw_len       (len),
      .spi_d_rise_align (align),
      .spi_wdata        (wdata),
      .spi_wr_en        (wr_en),
      .spi_rd_en        (rd_en),
      .spi_rdata        (rdata),
      .spi_busy         (busy),
      .spi_done         (done),
      .spi_csb          (csb),
      .spi_sclk         (sclk),
      .spi_mosi         (mosi),
      .spi_miso         (miso)
    );

    function automatic logic [31:0] nmask(input int n);
      logic [31:0] one = 32'd1;
      return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'd1);
    endfunction

    // One request; observes the whole frame plus a tail and compares it with the timing rules
    task automatic run_frame(input bit wr, input bit rd, input logic [4:0] l, input bit a,
                             input logic [31:0] wd, input logic [31:0] sd, input bit inject);
      int n = int'(l) + 1;
      int limit = (2 * n + 3) * D + 12;
      int csb_low = 0, first_low = -1, rises = 0, dones = 0, done_k = -1, busy_low_k = -1;
      int sidx = n - 1;
      logic [31:0] mosi_bits = '0;
      logic [31:0] rdata_at_done = '0;
      logic prev_sclk = 1'b0, prev_csb = 1'b1;
      string pfx = $sformatf("D%0d len%0d a%0d", D, l, a);

      @(negedge clk);
      len = l; align = a; wdata = wd; wr_en = wr; rd_en = rd;
      for (int k = 1; k <= limit; k++) begin
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        len = 5'($urandom); align = 1'($urandom); wdata = $urandom;
        if (!csb) begin
          csb_low++;
          if (first_low < 0) first_low = k;
        end
        if (!csb && prev_csb && !a) begin
          miso = sd[n - 1];
          sidx = n - 2;
        end
        if (sclk && !prev_sclk) begin
          rises++;
          mosi_bits = {mosi_bits[30:0], mosi};
          if (a) begin
            miso = (sidx >= 0) ? sd[sidx] : 1'b0;
            sidx--;
          end
        end
        if (!sclk && prev_sclk && !a) begin
          miso = (sidx >= 0) ? sd[sidx] : 1'b0;
          sidx--;
        end
        if (done) begin
          dones++;
          done_k = k;
          rdata_at_done = rdata;
        end
        if (!busy && busy_low_k < 0) busy_low_k = k;
        prev_sclk = sclk;
        prev_csb  = csb;
        if (inject && k == 5) wr_en = 1'b1;
        if (inject && k == (2 * n + 3) * D) rd_en = 1'b1;
      end

      if (rd) exp_rdata = sd & nmask(n);
      check_eq({pfx, " csb_low_cycles"}, csb_low, (2 * n + 2) * D);
      check_eq({pfx, " csb_first_low"}, first_low, 1);
      check_eq({pfx, " sclk_rises"}, rises, n);
      check_eq({pfx, " mosi_bits"}, mosi_bits, wd & nmask(n));
      check_eq({pfx, " done_pulses"}, dones, 1);
      check_eq({pfx, " done_cycle"}, done_k, (2 * n + 2) * D + 1);
      check_eq({pfx, " busy_low_cycle"}, busy_low_k, (2 * n + 3) * D + 1);
      check_eq({pfx, " rdata_at_done"}, rdata_at_done, exp_rdata);
      check_eq({pfx, " sclk_idle"}, {31'd0, sclk}, 32'd0);
      $display("D=%0d frame rd=%0d len=%0d align=%0d wdata=%h slave=%h rdata=%h",
               D, rd, l, a, wd, sd, rdata);
    endtask

    initial begin
      rstb = 1'b0; len = '0; align = 1'b0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
      miso = 1'b0; exp_rdata = '0;
      repeat (3) @(negedge clk);
      check_eq($sformatf("D%0d reset csb", D), {31'd0, csb}, 32'd1);
      check_eq($sformatf("D%0d reset sclk", D), {31'd0, sclk}, 32'd0);
      check_eq($sformatf("D%0d reset mosi", D), {31'd0, mosi}, 32'd0);
      check_eq($sformatf("D%0d reset busy", D), {31'd0, busy}, 32'd0);
      check_eq($sformatf("D%0d reset done", D), {31'd0, done}, 32'd0);
      check_eq($sformatf("D%0d reset rdata", D), rdata, 32'd0);
      rstb = 1'b1;
      repeat (2) @(negedge clk);

      run_frame(1'b1, 1'b0, 5'd7, 1'b0, 32'h0000_00A5, $urandom, 1'b0);
      run_frame(1'b0, 1'b1, 5'd7, 1'b0, $urandom, 32'h0000_003C, 1'b0);
      run_frame(1'b0, 1'b1, 5'd31, 1'b1, 32'h8000_0001, 32'hDEAD_BEEF, 1'b0);
      run_frame(1'b0, 1'b1, 5'd7, 1'b0, $urandom, $urandom, 1'b1);
      run_frame(1'b1, 1'b1, 5'd3, 1'b0, $urandom, 32'h0000_000A, 1'b0);
      for (int i = 0; i < 6; i++) begin
        bit rd_r = 1'($urandom);
        run_frame(!rd_r, rd_r, 5'($urandom), 1'($urandom), $urandom, $urandom, 1'b0);
      end
      run_frame(1'b0, 1'b1, 5'd15, 1'b1, $urandom, 32'h0000_9A5F, 1'b0);

      // Reset in the middle of a read frame must abort at once and clear read data
      @(negedge clk);
      len = 5'd31; align = 1'b0; wdata = $urandom; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (7 * D) @(negedge clk);
      check_eq($sformatf("D%0d pre-reset busy", D), {31'd0, busy}, 32'd1);
      rstb = 1'b0;
      #1;
      exp_rdata = '0;
      check_eq($sformatf("D%0d abort csb", D), {31'd0, csb}, 32'd1);
      check_eq($sformatf("D%0d abort sclk", D), {31'd0, sclk}, 32'd0);
      check_eq($sformatf("D%0d abort busy", D), {31'd0, busy}, 32'd0);
      check_eq($sformatf("D%0d abort rdata", D), rdata, 32'd0);
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      $display("D=%0d reset asserted mid-frame and released", D);
      run_frame(1'b0, 1'b1, 5'd11, 1'b1, $urandom, $urandom, 1'b0);

      blk_done[gi] = 1'b1;
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clk);
      all_done = blk_done[0] && blk_done[1] && blk_done[2];
    end
    if (!all_done) check_eq("timeout all_blocks_done", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
